// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: data width, ALU op codes
// and the controller FSM state encoding.
package alu_share_ctrl_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_LAST = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Core 32-bit ALU, purely combinational. Op codes above OP_LAST yield zero.
module alu_core
   import alu_share_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] res
);

   // Operation select; shifts use only the low five bits of b.
   always_comb begin
      res = {DATA_W{1'b0}};
      case (op)
         OP_ADD:  res = a + b;
         OP_SUB:  res = a - b;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_SLL:  res = a << b[4:0];
         OP_SRL:  res = a >> b[4:0];
         OP_SRA:  res = DATA_W'($signed(a) >>> b[4:0]);
         OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
         OP_MUL:  res = a * b;
         default: res = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching ptr+1, ptr+2, ... modulo N.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic [N-1:0] upper;
   logic         found;

   // Requests above ptr win first; otherwise wrap to the lowest index.
   always_comb begin
      upper = {N{1'b0}};
      grant = {N{1'b0}};
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         upper[i] = req[i] && (PW'(i) > ptr);
      end
      for (int i = 0; i < N; i++) begin
         if (!found && upper[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end else begin
            grant[i] = grant[i];
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end else begin
            grant[i] = grant[i];
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one core ALU among N_REQ requesters: round-robin grant, one op in
// flight, MUL held for MUL_LAT execute cycles, response held until accepted.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int MUL_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [DATA_W*N_REQ-1:0] req_a,
   input  logic [DATA_W*N_REQ-1:0] req_b,
   input  logic [4*N_REQ-1:0]      req_op,
   output logic [N_REQ-1:0]        resp_valid,
   input  logic [N_REQ-1:0]        resp_ready,
   output logic [DATA_W-1:0]       resp_res,
   output logic                    resp_illegal,
   output logic                    busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MUL_LAT + 1);

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    owner_q, owner_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]          op_q, op_d;
   logic                ill_q, ill_d;

   logic [N_REQ-1:0]    grant;
   logic [PTR_W-1:0]    g_idx;
   logic [DATA_W-1:0]   sel_a, sel_b, alu_res;
   logic [3:0]          sel_op;
   logic                accept;

   rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   alu_core u_alu (
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .res (alu_res)
   );

   // Encode the grant and select the granted requester's operands.
   always_comb begin
      g_idx  = {PTR_W{1'b0}};
      sel_a  = {DATA_W{1'b0}};
      sel_b  = {DATA_W{1'b0}};
      sel_op = 4'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            g_idx  = PTR_W'(i);
            sel_a  = req_a[i*DATA_W +: DATA_W];
            sel_b  = req_b[i*DATA_W +: DATA_W];
            sel_op = req_op[i*4 +: 4];
         end else begin
            g_idx = g_idx;
         end
      end
   end

   assign accept = |(req_ready & req_valid);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = RESP;
            end else begin
               state_d = EXEC;
            end
         end
         RESP: begin
            if (resp_ready[owner_q]) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; req_ready is held low while reset is asserted.
   always_comb begin
      req_ready    = {N_REQ{1'b0}};
      resp_valid   = {N_REQ{1'b0}};
      resp_res     = {DATA_W{1'b0}};
      resp_illegal = 1'b0;
      busy         = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (!rst) begin
               req_ready = grant;
            end else begin
               req_ready = {N_REQ{1'b0}};
            end
         end
         EXEC: req_ready = {N_REQ{1'b0}};
         RESP: begin
            resp_valid   = N_REQ'(1) << owner_q;
            resp_res     = res_q;
            resp_illegal = ill_q;
         end
         default: req_ready = {N_REQ{1'b0}};
      endcase
   end

   // Datapath registers; the ALU only ever sees the latched operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= PTR_W'(N_REQ - 1);
         owner_q <= {PTR_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         a_q     <= {DATA_W{1'b0}};
         b_q     <= {DATA_W{1'b0}};
         op_q    <= 4'd0;
         res_q   <= {DATA_W{1'b0}};
         ill_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
      end
   end

   // Datapath next values: capture on accept, count down, then register result.
   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      ill_d   = ill_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               ptr_d   = g_idx;
               owner_d = g_idx;
               a_d     = sel_a;
               b_d     = sel_b;
               op_d    = sel_op;
               cnt_d   = (sel_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : {CNT_W{1'b0}};
            end else begin
               ptr_d = ptr_q;
            end
         end
         EXEC: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               res_d = alu_res;
               ill_d = (op_q > OP_LAST);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    res_d = res_q;
         default: res_d = res_q;
      endcase
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with two requesters and a 3-cycle MUL.
module tb_alu_share_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [7:0]  req_op;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [31:0] resp_res;
   logic        resp_illegal;
   logic        busy;

   typedef struct {
      int          owner;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu_share_ctrl #(.N_REQ(2), .MUL_LAT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_op       (req_op),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_res     (resp_res),
      .resp_illegal (resp_illegal),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [63:0] prod;
      logic [31:0] r;
      int          sh;
      sh = int'(b[4:0]);
      r  = 32'd0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a + (~b) + 32'd1;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << sh;
         4'd6:  r = a >> sh;
         4'd7: begin
            r = a;
            for (int k = 0; k < sh; k++) r = {r[31], r[31:1]};
         end
         4'd8: begin
            if (a[31] != b[31]) r = {31'd0, a[31]};
            else                r = {31'd0, (a[30:0] < b[30:0])};
         end
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: begin
            prod = {32'd0, a} * {32'd0, b};
            r    = prod[31:0];
         end
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
      req_a[idx*32 +: 32] = a;
      req_b[idx*32 +: 32] = b;
      req_op[idx*4 +: 4]  = op;
      req_valid[idx]      = 1'b1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_grant(output int g, output bit ok);
      logic [1:0] hit;
      g  = -1;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         #1;
         hit = req_valid & req_ready;
         if (hit != 2'b00) begin
            ok = 1'b1;
            g  = hit[1] ? 1 : 0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic wait_resp(input logic [1:0] clr, output logic [1:0] rv,
                            output logic [31:0] res, output logic ill,
                            output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      rv  = 2'b00;
      res = 32'd0;
      ill = 1'b0;
      while (!ok && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) req_valid = req_valid & ~clr;
         if (resp_valid != 2'b00) begin
            ok  = 1'b1;
            rv  = resp_valid;
            res = resp_res;
            ill = resp_illegal;
         end
      end
   endtask

   task automatic ack(input int o);
      resp_ready[o] = 1'b1;
      @(negedge clk);
      resp_ready = 2'b00;
   endtask

   // One isolated op: push the expectation, run it, pop and compare.
   task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] exp_res,
                            input logic exp_ill, input string tag);
      int          g, lat;
      bit          ok;
      logic [1:0]  rv;
      logic [31:0] res;
      logic        ill;
      exp_t        e;
      set_req(idx, a, b, op);
      exp_q.push_back('{owner: idx, res: exp_res, ill: exp_ill, lat: (op == 4'd10) ? 4 : 2});
      wait_grant(g, ok);
      checks++;
      if (!ok || g != idx) begin
         errors++;
         $display("FAIL %s grant: got %0d ok=%0d, want %0d", tag, g, ok, idx);
      end
      wait_resp(2'b01 << idx, rv, res, ill, lat, ok);
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", tag);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (!ok || rv !== (2'b01 << e.owner)) begin
         errors++;
         $display("FAIL %s resp_valid: got %b, want %b", tag, rv, 2'b01 << e.owner);
      end
      checks++;
      if (res !== e.res || ill !== e.ill) begin
         errors++;
         $display("FAIL %s result: got %h ill=%b, want %h ill=%b", tag, res, ill, e.res, e.ill);
      end
      checks++;
      if (lat != e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d, want %0d", tag, lat, e.lat);
      end
      ack(idx);
      checks++;
      if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_res !== 32'd0) begin
         errors++;
         $display("FAIL %s idle after ack: busy=%b rv=%b res=%h, want 0 00 0", tag, busy,
                  resp_valid, resp_res);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      req_valid  = 2'b11;
      resp_ready = 2'b00;
      req_a = 64'd0; req_b = 64'd0; req_op = 8'd0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0 ||
          resp_res !== 32'd0 || resp_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset state: rdy=%b rv=%b busy=%b res=%h ill=%b, want all 0",
                  req_ready, resp_valid, busy, resp_res, resp_illegal);
      end
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_wrap();
      do_reset();
      single_op(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b0, "add_wrap");
   endtask

   task automatic test_round_robin();
      int          g, lat;
      bit          ok;
      logic [1:0]  rv;
      logic [31:0] res;
      logic        ill;
      exp_t        e;
      do_reset();
      set_req(0, 32'd5, 32'd7, 4'd1);
      set_req(1, 32'd5, 32'd7, 4'd1);
      for (int n = 0; n < 10; n++) begin
         wait_grant(g, ok);
         checks++;
         if (!ok || g != (n % 2)) begin
            errors++;
            $display("FAIL rr grant op%0d: got %0d, want %0d", n, g, n % 2);
         end
         exp_q.push_back('{owner: n % 2, res: 32'hFFFF_FFFE, ill: 1'b0, lat: 2});
         wait_resp(2'b00, rv, res, ill, lat, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || rv !== (2'b01 << e.owner) || res !== e.res) begin
            errors++;
            $display("FAIL rr resp op%0d: got rv=%b res=%h, want rv=%b res=%h", n, rv, res,
                     2'b01 << e.owner, e.res);
         end
         ack(e.owner);
      end
      req_valid = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_mul_latency();
      do_reset();
      single_op(1, 32'h0001_0000, 32'h0001_0000, 4'd10, 32'd0, 1'b0, "mul_wrap");
      single_op(0, 32'h0001_2345, 32'h0000_0100, 4'd10, 32'h0123_4500, 1'b0, "mul_small");
   endtask

   task automatic test_backpressure();
      int          g, lat;
      bit          ok;
      logic [1:0]  rv;
      logic [31:0] res;
      logic        ill;
      do_reset();
      set_req(0, 32'h8000_0000, 32'd31, 4'd7);
      wait_grant(g, ok);
      wait_resp(2'b01, rv, res, ill, lat, ok);
      checks++;
      if (!ok || rv !== 2'b01 || res !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sra resp: got rv=%b res=%h, want 01 ffffffff", rv, res);
      end
      set_req(1, 32'd10, 32'd20, 4'd0);
      resp_ready[1] = 1'b1;
      for (int n = 0; n < 5; n++) begin
         #1;
         checks++;
         if (resp_valid !== 2'b01 || resp_res !== 32'hFFFF_FFFF || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL stall cyc%0d: rv=%b res=%h rdy=%b, want 01 ffffffff 00", n,
                     resp_valid, resp_res, req_ready);
         end
         @(negedge clk);
      end
      resp_ready = 2'b00;
      ack(0);
      req_valid[1] = 1'b0;
      single_op(1, 32'd10, 32'd20, 4'd0, 32'd30, 1'b0, "after_stall");
   endtask

   task automatic test_illegal_slt();
      do_reset();
      single_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'hC, 32'd0, 1'b1, "illegal");
      single_op(1, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd1, 1'b0, "slt");
      single_op(0, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd0, 1'b0, "sltu");
   endtask

   task automatic test_random_ops();
      logic [31:0] a, b;
      logic [3:0]  op;
      int          idx;
      do_reset();
      for (int n = 0; n < 16; n++) begin
         a   = $urandom;
         b   = $urandom;
         op  = 4'($urandom_range(0, 15));
         idx = $urandom_range(0, 1);
         single_op(idx, a, b, op, model_alu(a, b, op), (op > 4'd10), "random");
      end
   endtask

   task automatic test_reset_mid_op();
      int g;
      bit ok;
      do_reset();
      set_req(0, 32'd6, 32'd7, 4'd10);
      wait_grant(g, ok);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 2'b00;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset mid-op cyc%0d: rv=%b busy=%b rdy=%b, want 00 0 00", n,
                     resp_valid, busy, req_ready);
         end
      end
      rst = 1'b0;
      set_req(0, 32'd1, 32'd2, 4'd0);
      set_req(1, 32'd3, 32'd4, 4'd0);
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset priority: rdy=%b, want 01", req_ready);
      end
      req_valid = 2'b00;
      single_op(0, 32'd1, 32'd2, 4'd0, 32'd3, 1'b0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_round_robin();
      test_mul_latency();
      test_backpressure();
      test_illegal_slt();
      test_random_ops();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
